// File: rtl/uart_rx_buffer_ctrl.sv
// uart_rx_buffer_ctrl: receive-side byte FIFO behind the UART receiver with
// overflow/error status tracking and an idle timeout for unread partial data.
// Optional feature macro: UART_RX_CTRL_FLUSH_EN (enables the flush input).
module uart_rx_buffer_ctrl #(
    parameter int Depth         = 8,
    parameter int TimeoutCycles = 160
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rxData,
    input  logic                     rxDone,
    input  logic                     rxErr,
    output logic [7:0]               outData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [$clog2(Depth):0]   count,
    output logic                     overflow,
    output logic [7:0]               errCount,
    output logic                     timeout,
    input  logic                     clearStatus,
    input  logic                     flush
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        TIMED   = 2'd2
    } state_t;

    logic [7:0]    mem [Depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_nxt;
    logic [TW-1:0] timer_q, timer_nxt;
    state_t        state_q, state_nxt;

    logic flush_act;
    logic push, pop, full;
    logic push_ok, pop_ok, drop;

`ifdef UART_RX_CTRL_FLUSH_EN
    assign flush_act = flush;
`else
    // Flush input is accepted at the port but has no effect in this build.
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_act    = 1'b0;
`endif

    assign push    = rxDone & ~rxErr;
    assign pop     = outValid & outReady;
    assign full    = (count_q == CW'(Depth));
    // A push into a full FIFO is still accepted when the head leaves the same cycle.
    assign push_ok = push & ~flush_act & (~full | pop);
    assign pop_ok  = pop & ~flush_act;
    assign drop    = push & ~flush_act & full & ~pop;

    assign outValid = (count_q != '0);
    assign outData  = mem[rd_ptr];
    assign count    = count_q;
    assign timeout  = (state_q == TIMED);

    // Occupancy after this cycle's push/pop/flush.
    always_comb begin
        count_nxt = count_q;
        if (flush_act)
            count_nxt = '0;
        else if (push_ok & ~pop_ok)
            count_nxt = count_q + 1'b1;
        else if (~push_ok & pop_ok)
            count_nxt = count_q - 1'b1;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) mem[wr_ptr] <= rxData;
            if (flush_act) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_nxt;
        end
    end

    // Sticky overflow and saturating error count; a new event beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            errCount <= '0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            else if (clearStatus)
                overflow <= 1'b0;

            if (rxErr) begin
                if (clearStatus)
                    errCount <= 8'd1;
                else if (errCount != 8'hFF)
                    errCount <= errCount + 8'd1;
            end else if (clearStatus) begin
                errCount <= '0;
            end
        end
    end

    // Timeout state and idle timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            timer_q <= '0;
        end else begin
            state_q <= state_nxt;
            timer_q <= timer_nxt;
        end
    end

    // Next state: empty FIFO wins, then an accepted push restarts the timer.
    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        if (count_nxt == '0) begin
            state_nxt = EMPTY;
            timer_nxt = '0;
        end else if (push_ok) begin
            state_nxt = PENDING;
            timer_nxt = '0;
        end else begin
            case (state_q)
                PENDING: begin
                    if (timer_q == TW'(TimeoutCycles - 1))
                        state_nxt = TIMED;
                    else
                        timer_nxt = timer_q + 1'b1;
                end
                TIMED:   state_nxt = TIMED;
                default: state_nxt = state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Directed testbench for uart_rx_buffer_ctrl: vector table plus hand sequences.
module tb_uart_rx_buffer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rxData;
    logic       rxDone, rxErr, outReady, clearStatus, flush;
    logic [7:0] outData;
    logic       outValid, overflow, timeout;
    logic [3:0] count;
    logic [7:0] errCount;

    int total = 0;
    int bad   = 0;

    uart_rx_buffer_ctrl #(.Depth(8), .TimeoutCycles(160)) dut (
        .clk(clk), .reset(reset), .rxData(rxData), .rxDone(rxDone), .rxErr(rxErr),
        .outData(outData), .outValid(outValid), .outReady(outReady), .count(count),
        .overflow(overflow), .errCount(errCount), .timeout(timeout),
        .clearStatus(clearStatus), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       dn;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] ec;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [7:0] d, logic dn, logic rdy, logic clr,
                                logic ev, logic [7:0] ed, logic [3:0] ec, logic eo);
        vec_t v;
        v.d = d; v.dn = dn; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rxData = 8'h00; rxDone = 1'b0; rxErr = 1'b0;
        outReady = 1'b0; clearStatus = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic fill(logic [7:0] base, int n);
        for (int k = 0; k < n; k++) begin
            rxData = base + 8'(k);
            rxDone = 1'b1;
            tick();
        end
        rxDone = 1'b0;
    endtask

    logic [7:0] exp_q[8];
    int         n;

    initial begin
        idle_inputs();
        do_reset();
        check("reset_count", count, 0);
        check("reset_valid", outValid, 0);
        check("reset_data", outData, 0);
        check("reset_ovf", overflow, 0);
        check("reset_err", errCount, 0);
        check("reset_tmo", timeout, 0);

        // Vector table: single push/pop, overflow fill, in-order drain, clear.
        vecs.push_back(mk(8'hA5, 1, 0, 0, 1, 8'hA5, 1, 0));
        vecs.push_back(mk(8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(8'(k), 1, 0, 0, 1, 8'h01, 4'(k), 0));
        vecs.push_back(mk(8'h09, 1, 0, 0, 1, 8'h01, 8, 1));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(8'h00, 0, 1, 0, (i < 8), 8'(i + 1), 4'(8 - i), 1));
        vecs.push_back(mk(8'h00, 0, 0, 1, 0, 8'h00, 0, 0));

        foreach (vecs[i]) begin
            rxData = vecs[i].d; rxDone = vecs[i].dn;
            outReady = vecs[i].rdy; clearStatus = vecs[i].clr;
            tick();
            check($sformatf("vec%0d_valid", i), outValid, vecs[i].ev);
            check($sformatf("vec%0d_count", i), count, vecs[i].ec);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].eo);
            if (vecs[i].ev)
                check($sformatf("vec%0d_data", i), outData, vecs[i].ed);
        end
        idle_inputs();

        // Full FIFO, push with simultaneous pop: no overflow, byte lands at tail.
        fill(8'h11, 8);
        check("full_count", count, 8);
        rxData = 8'h55; rxDone = 1'b1; outReady = 1'b1;
        tick();
        rxDone = 1'b0;
        check("fullpp_count", count, 8);
        check("fullpp_ovf", overflow, 0);
        for (int k = 0; k < 7; k++) exp_q[k] = 8'h12 + 8'(k);
        exp_q[7] = 8'h55;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fullpp_drain%0d", k), outData, exp_q[k]);
            tick();
        end
        check("fullpp_empty", count, 0);
        outReady = 1'b0;

        // Overflow arriving together with clearStatus wins.
        fill(8'h20, 8);
        rxData = 8'h99; rxDone = 1'b1; clearStatus = 1'b1;
        tick();
        rxDone = 1'b0;
        check("ovf_clr_same", overflow, 1);
        check("ovf_clr_count", count, 8);
        tick();
        clearStatus = 1'b0;
        check("ovf_cleared", overflow, 0);
        outReady = 1'b1;
        repeat (8) tick();
        outReady = 1'b0;
        check("ovf_drained", count, 0);

        // Error counter saturation and error-tagged bytes.
        rxErr = 1'b1;
        repeat (300) tick();
        rxErr = 1'b0;
        check("err_sat", errCount, 8'hFF);
        rxData = 8'h33; rxDone = 1'b1; rxErr = 1'b1;
        tick();
        rxDone = 1'b0; rxErr = 1'b0;
        check("err_nopush_count", count, 0);
        check("err_nopush_valid", outValid, 0);
        check("err_still_sat", errCount, 8'hFF);
        rxErr = 1'b1; clearStatus = 1'b1;
        tick();
        rxErr = 1'b0;
        check("err_clr_same", errCount, 1);
        tick();
        clearStatus = 1'b0;
        check("err_cleared", errCount, 0);

        // Idle timeout with a byte pending.
        rxData = 8'h77; rxDone = 1'b1;
        tick();
        rxDone = 1'b0;
        check("tmo_after_push", timeout, 0);
        n = 0;
        while (!timeout && n < 400) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 160);
        rxData = 8'h78; rxDone = 1'b1;
        tick();
        rxDone = 1'b0;
        check("tmo_repush", timeout, 0);
        check("tmo_repush_count", count, 2);
        repeat (10) tick();
        check("tmo_restart_low", timeout, 0);
        outReady = 1'b1;
        check("tmo_head", outData, 8'h77);
        tick();
        tick();
        outReady = 1'b0;
        check("tmo_pop_count", count, 0);
        check("tmo_pop_tmo", timeout, 0);
        repeat (200) tick();
        check("tmo_empty_idle", timeout, 0);

`ifdef UART_RX_CTRL_FLUSH_EN
        // Flush empties the FIFO and discards a same-cycle push; status is kept.
        rxErr = 1'b1;
        tick();
        rxErr = 1'b0;
        fill(8'h40, 5);
        check("flush_pre", count, 5);
        rxData = 8'hEE; rxDone = 1'b1; flush = 1'b1;
        tick();
        rxDone = 1'b0; flush = 1'b0;
        check("flush_count", count, 0);
        check("flush_valid", outValid, 0);
        check("flush_err_kept", errCount, 1);
        check("flush_tmo", timeout, 0);
        fill(8'h60, 1);
        check("flush_after_data", outData, 8'h60);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
`endif

        // Reset during a push clears everything.
        fill(8'h80, 9);
        rxErr = 1'b1;
        tick();
        rxErr = 1'b0;
        check("pre_rst_ovf", overflow, 1);
        rxData = 8'hC3; rxDone = 1'b1; reset = 1'b1;
        tick();
        rxDone = 1'b0; reset = 1'b0;
        check("rst_count", count, 0);
        check("rst_valid", outValid, 0);
        check("rst_data", outData, 0);
        check("rst_ovf", overflow, 0);
        check("rst_err", errCount, 0);
        check("rst_tmo", timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
